mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Two-port arbiter in front of a shared single-port data memory.
// Port 0 is a read-only fetch requester and port 1 is a load/store
// requester. Port 1 wins under contention until port 0 has lost STARVE_MAX
// consecutive contended cycles. Port 0 is then forced through and the
// starvation count restarts.
//
// Grants and the memory command are combinational from the requests and
// the starvation state. Read data is registered from mem_rd at the end of
// the grant cycle, so a read has one cycle of latency.
//
// Ports
//   clk                     single clock, rising edge
//   reset                   asynchronous reset, active-low
//   p0_req, p0_addr         fetch read request
//   p0_gnt                  fetch request accepted this cycle
//   p0_rvalid, p0_rdata     fetch read response
//   p1_req, p1_we, p1_addr,
//   p1_wdata                data request (we: 00 rd, 01 word, 10 half, 11 byte)
//   p1_gnt                  data request accepted this cycle
//   p1_rvalid, p1_rdata     data read response
//   mem_we, mem_a, mem_wd   command to the shared memory
//   mem_rd                  combinational read data from the shared memory
//   starve_cnt              current port-0 starvation count
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p0_req,
    input  logic [31:0] p0_addr,
    output logic        p0_gnt,
    output logic        p0_rvalid,
    output logic [31:0] p0_rdata,
    input  logic        p1_req,
    input  logic [1:0]  p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_rvalid,
    output logic [31:0] p1_rdata,
    output logic [1:0]  mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd,
    output logic [3:0]  starve_cnt
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0]  starve_q, starve_d;
    logic        gnt0, gnt1;
    logic        p0_rvalid_q, p0_rvalid_d;
    logic        p1_rvalid_q, p1_rvalid_d;
    logic [31:0] p0_rdata_q, p0_rdata_d;
    logic [31:0] p1_rdata_q, p1_rdata_d;

    // Arbitration and starvation counter next state
    always_comb begin
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        starve_d = 4'd0;
        if (p0_req && p1_req) begin
            // >= rather than == keeps port 0 from starving forever if the
            // count were ever to hold an out-of-range value.
            if (starve_q >= STARVE_LIM) begin
                gnt0 = 1'b1;
            end else begin
                gnt1     = 1'b1;
                starve_d = starve_q + 4'd1;
            end
        end else begin
            gnt0 = p0_req;
            gnt1 = p1_req;
        end
        // Grants, and therefore the memory command, are held off
        // asynchronously while reset is asserted.
        if (!reset) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    // Memory command from whichever port holds the grant
    always_comb begin
        mem_we = 2'b00;
        mem_a  = 32'd0;
        mem_wd = 32'd0;
        if (gnt1) begin
            mem_we = p1_we;
            mem_a  = p1_addr;
            mem_wd = p1_wdata;
        end else if (gnt0) begin
            mem_a  = p0_addr;
        end
    end

    // Read-response capture; p1 writes leave p1_rdata untouched
    always_comb begin
        p0_rvalid_d = gnt0;
        p1_rvalid_d = gnt1 && (p1_we == 2'b00);
        p0_rdata_d  = gnt0 ? mem_rd : p0_rdata_q;
        p1_rdata_d  = p1_rvalid_d ? mem_rd : p1_rdata_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_q    <= 4'd0;
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            p0_rdata_q  <= 32'd0;
            p1_rdata_q  <= 32'd0;
        end else begin
            starve_q    <= starve_d;
            p0_rvalid_q <= p0_rvalid_d;
            p1_rvalid_q <= p1_rvalid_d;
            p0_rdata_q  <= p0_rdata_d;
            p1_rdata_q  <= p1_rdata_d;
        end
    end

    assign p0_gnt     = gnt0;
    assign p1_gnt     = gnt1;
    assign p0_rvalid  = p0_rvalid_q;
    assign p1_rvalid  = p1_rvalid_q;
    assign p0_rdata   = p0_rdata_q;
    assign p1_rdata   = p1_rdata_q;
    assign starve_cnt = starve_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Bench for mem_arbiter with STARVE_MAX = 3. A table of per-cycle vectors
// gives the inputs and the expected grants and starvation count. Expected
// read responses are queued when a read grant is expected and are popped
// after the next clock edge. Hand-written sequences cover reset.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        p0_req;
    logic [31:0] p0_addr;
    logic        p0_gnt;
    logic        p0_rvalid;
    logic [31:0] p0_rdata;
    logic        p1_req;
    logic [1:0]  p1_we;
    logic [31:0] p1_addr;
    logic [31:0] p1_wdata;
    logic        p1_gnt;
    logic        p1_rvalid;
    logic [31:0] p1_rdata;
    logic [1:0]  mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
    logic [3:0]  starve_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    mem_arbiter #(.STARVE_MAX(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .p0_req    (p0_req),
        .p0_addr   (p0_addr),
        .p0_gnt    (p0_gnt),
        .p0_rvalid (p0_rvalid),
        .p0_rdata  (p0_rdata),
        .p1_req    (p1_req),
        .p1_we     (p1_we),
        .p1_addr   (p1_addr),
        .p1_wdata  (p1_wdata),
        .p1_gnt    (p1_gnt),
        .p1_rvalid (p1_rvalid),
        .p1_rdata  (p1_rdata),
        .mem_we    (mem_we),
        .mem_a     (mem_a),
        .mem_wd    (mem_wd),
        .mem_rd    (mem_rd),
        .starve_cnt(starve_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        p0_req;
        logic [31:0] p0_addr;
        logic        p1_req;
        logic [1:0]  p1_we;
        logic [31:0] p1_addr;
        logic [31:0] p1_wdata;
        logic [31:0] mem_rd;
        logic        eg0;
        logic        eg1;
        logic [3:0]  est;
    } vec_t;

    typedef struct {
        bit          port;
        logic [31:0] data;
    } rsp_t;

    vec_t vecs[$];
    rsp_t sbq[$];
    logic [31:0] exp_p0_rdata;
    logic [31:0] exp_p1_rdata;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic r0, input logic [31:0] a0,
                                input logic r1, input logic [1:0] we,
                                input logic [31:0] a1, input logic [31:0] wd,
                                input logic [31:0] rd, input logic eg0,
                                input logic eg1, input logic [3:0] est);
        vec_t v;
        v.p0_req = r0;  v.p0_addr = a0;
        v.p1_req = r1;  v.p1_we = we;  v.p1_addr = a1;  v.p1_wdata = wd;
        v.mem_rd = rd;  v.eg0 = eg0;  v.eg1 = eg1;  v.est = est;
        return v;
    endfunction

    // Invariants checked on every cycle, including during reset
    always @(negedge clk) begin
        chk1("one_hot_gnt", p0_gnt && p1_gnt, 1'b0);
        if (!p1_gnt) chk32("mem_we_idle", 32'(mem_we), 32'd0);
    end

    // One table cycle: drive, compare combinational outputs mid-cycle,
    // queue the expected response, then compare registered outputs.
    task automatic run_vec(input vec_t v);
        bit got0, got1;
        rsp_t r;
        p0_req = v.p0_req;  p0_addr = v.p0_addr;
        p1_req = v.p1_req;  p1_we = v.p1_we;  p1_addr = v.p1_addr;
        p1_wdata = v.p1_wdata;  mem_rd = v.mem_rd;
        @(negedge clk);
        chk1("p0_gnt", p0_gnt, v.eg0);
        chk1("p1_gnt", p1_gnt, v.eg1);
        chk32("starve_cnt", 32'(starve_cnt), 32'(v.est));
        if (v.eg1) begin
            chk32("mem_we", 32'(mem_we), 32'(v.p1_we));
            chk32("mem_a", mem_a, v.p1_addr);
            chk32("mem_wd", mem_wd, v.p1_wdata);
            if (v.p1_we == 2'b00) begin
                r.port = 1'b1;  r.data = v.mem_rd;  sbq.push_back(r);
            end
        end else if (v.eg0) begin
            chk32("mem_we", 32'(mem_we), 32'd0);
            chk32("mem_a", mem_a, v.p0_addr);
            chk32("mem_wd", mem_wd, 32'd0);
            r.port = 1'b0;  r.data = v.mem_rd;  sbq.push_back(r);
        end else begin
            chk32("mem_a_idle", mem_a, 32'd0);
            chk32("mem_wd_idle", mem_wd, 32'd0);
        end
        @(posedge clk);
        #1;
        got0 = 1'b0;
        got1 = 1'b0;
        while (sbq.size() > 0) begin
            r = sbq.pop_front();
            if (r.port) begin got1 = 1'b1; exp_p1_rdata = r.data; end
            else        begin got0 = 1'b1; exp_p0_rdata = r.data; end
        end
        chk1("p0_rvalid", p0_rvalid, got0);
        chk1("p1_rvalid", p1_rvalid, got1);
        chk32("p0_rdata", p0_rdata, exp_p0_rdata);
        chk32("p1_rdata", p1_rdata, exp_p1_rdata);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        p0_req = 1'b1;  p0_addr = 32'h0;  p1_req = 1'b1;  p1_we = 2'b01;
        p1_addr = 32'h0;  p1_wdata = 32'h0;  mem_rd = 32'h0;
        exp_p0_rdata = 32'd0;
        exp_p1_rdata = 32'd0;

        // Reset state while requests are active and the clock runs
        #12;
        chk1("rst_p0_gnt", p0_gnt, 1'b0);
        chk1("rst_p1_gnt", p1_gnt, 1'b0);
        chk32("rst_mem_we", 32'(mem_we), 32'd0);
        chk1("rst_p0_rvalid", p0_rvalid, 1'b0);
        chk1("rst_p1_rvalid", p1_rvalid, 1'b0);
        chk32("rst_starve", 32'(starve_cnt), 32'd0);
        chk32("rst_p0_rdata", p0_rdata, 32'd0);
        chk32("rst_p1_rdata", p1_rdata, 32'd0);
        p0_req = 1'b0;
        p1_req = 1'b0;
        reset  = 1'b1;
        @(posedge clk);
        #1;

        //           p0  p0_addr       p1  we     p1_addr       p1_wdata      mem_rd        g0 g1 st
        vecs.push_back(mk(1, 32'h10,  0, 2'b00, 32'h0,   32'h0,    32'hDEADBEEF, 1, 0, 0));
        vecs.push_back(mk(0, 32'h0,   1, 2'b11, 32'h23,  32'hAB,   32'h11111111, 0, 1, 0));
        vecs.push_back(mk(0, 32'h0,   0, 2'b00, 32'h0,   32'h0,    32'h22222222, 0, 0, 0));
        vecs.push_back(mk(0, 32'h0,   1, 2'b00, 32'h40,  32'h0,    32'h12345678, 0, 1, 0));
        vecs.push_back(mk(0, 32'h0,   1, 2'b01, 32'h44,  32'h55AA, 32'h33333333, 0, 1, 0));
        vecs.push_back(mk(0, 32'h0,   1, 2'b10, 32'h46,  32'hBEEF, 32'h44444444, 0, 1, 0));
        // Continuous contention: p1,p1,p1,p0 twice
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(1, 32'h100 + 32'(i), 1, 2'b00, 32'h200 + 32'(i), 32'h0,
                              32'hA0000000 + 32'(i), (i % 4) == 3, (i % 4) != 3, 4'(i % 4)));
        vecs.push_back(mk(0, 32'h0,   0, 2'b00, 32'h0,   32'h0,    32'h0,        0, 0, 0));
        // Two contended cycles, p1 drops for one, then contention again
        vecs.push_back(mk(1, 32'h300, 1, 2'b00, 32'h400, 32'h0,    32'hB0000000, 0, 1, 0));
        vecs.push_back(mk(1, 32'h300, 1, 2'b01, 32'h404, 32'h77,   32'hB0000001, 0, 1, 1));
        vecs.push_back(mk(1, 32'h300, 0, 2'b00, 32'h0,   32'h0,    32'hB0000002, 1, 0, 2));
        vecs.push_back(mk(1, 32'h304, 1, 2'b00, 32'h408, 32'h0,    32'hB0000003, 0, 1, 0));
        vecs.push_back(mk(0, 32'h0,   0, 2'b00, 32'h0,   32'h0,    32'h0,        0, 0, 1));
        vecs.push_back(mk(0, 32'h0,   0, 2'b00, 32'h0,   32'h0,    32'h0,        0, 0, 0));

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset asserted in the cycle after a p0 grant
        p0_req = 1'b1;  p0_addr = 32'h80;  p1_req = 1'b0;  mem_rd = 32'hCAFEF00D;
        @(negedge clk);
        chk1("pre_rst_p0_gnt", p0_gnt, 1'b1);
        @(posedge clk);
        #1;
        chk1("pre_rst_p0_rvalid", p0_rvalid, 1'b1);
        chk32("pre_rst_p0_rdata", p0_rdata, 32'hCAFEF00D);
        p1_req = 1'b1;  p1_we = 2'b00;
        reset = 1'b0;
        #1;
        chk1("mid_rst_p0_rvalid", p0_rvalid, 1'b0);
        chk32("mid_rst_p0_rdata", p0_rdata, 32'd0);
        chk32("mid_rst_starve", 32'(starve_cnt), 32'd0);
        chk1("mid_rst_p0_gnt", p0_gnt, 1'b0);
        chk1("mid_rst_p1_gnt", p1_gnt, 1'b0);
        chk32("mid_rst_mem_we", 32'(mem_we), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk1("held_rst_p0_rvalid", p0_rvalid, 1'b0);
        chk1("held_rst_p1_gnt", p1_gnt, 1'b0);

        // Release with contention: normal arbitration from starve_cnt = 0
        reset = 1'b1;  p1_we = 2'b01;
        @(negedge clk);
        chk1("rel_p1_gnt", p1_gnt, 1'b1);
        chk1("rel_p0_gnt", p0_gnt, 1'b0);
        chk32("rel_starve", 32'(starve_cnt), 32'd0);
        @(posedge clk);
        #1;
        chk1("rel_p0_rvalid", p0_rvalid, 1'b0);
        chk1("rel_p1_rvalid", p1_rvalid, 1'b0);
        chk32("rel_starve_next", 32'(starve_cnt), 32'd1);
        p0_req = 1'b0;  p1_req = 1'b0;
        @(posedge clk);
        #1;
        chk1("rel_p0_rvalid_late", p0_rvalid, 1'b0);
        chk32("rel_p0_rdata", p0_rdata, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
